// File: rtl/systolic_pq_head.sv
// Head controller of a systolic priority queue. It accepts insert and
// extract-min requests on alternate (even) cycles, keeps the occupancy count,
// and drives the registered entry pair (bo, ao) into systolic node 1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ins_rdy and ext_valid are high only on even cycles, so every
// transfer lands on an even-cycle edge. A held request waits for the next even
// cycle. Neither ready nor valid is a registered promise; both are recomputed
// from the phase and the count every cycle.
module systolic_pq_head #(
    parameter int KW         = 8,
    parameter int VW         = 4,
    parameter int CAPACITY   = 4,
    parameter int REPLACE_EN = 1,
    localparam int W         = KW + VW,
    localparam int CW        = $clog2(CAPACITY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          odd,
    output logic          even,
    input  logic          ins_valid,
    input  logic [W-1:0]  ins_data,
    output logic          ins_rdy,
    output logic          ext_valid,
    input  logic          ext_rdy,
    output logic [W-1:0]  ext_data,
    input  logic [W-1:0]  head_i,
    output logic [W-1:0]  bo,
    output logic [W-1:0]  ao,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [W-1:0] PQINF    = '1;
    localparam logic [W-1:0] PQNEGINF = '0;

    logic          ins_fire;
    logic          ext_fire;
    logic [W-1:0]  bo_next;
    logic [W-1:0]  ao_next;
    logic [CW-1:0] count_next;

    assign even      = ~odd;
    assign full      = (count == CW'(CAPACITY));
    assign empty     = (count == '0);
    assign ext_valid = even & ~empty;
    assign ext_data  = head_i;
    assign ext_fire  = ext_valid & ext_rdy;
    assign ins_fire  = ins_valid & ins_rdy;

    // With replace enabled an insert may ride along with an extract; without
    // it an extract that is firing blocks the insert for this even cycle.
    generate
        if (REPLACE_EN != 0) begin : g_replace
            assign ins_rdy = even & ~full;
        end else begin : g_ext_priority
            assign ins_rdy = even & ~full & ~ext_fire;
        end
    endgenerate

    // Choose the entry pair for node 1 and the new occupancy from the fires.
    always_comb begin
        bo_next    = PQINF;
        ao_next    = PQNEGINF;
        count_next = count;
        unique case ({ins_fire, ext_fire})
            2'b11: begin
                bo_next = ins_data;
                ao_next = PQINF;
            end
            2'b10: begin
                bo_next    = ins_data;
                count_next = count + CW'(1);
            end
            2'b01: begin
                ao_next    = PQINF;
                count_next = count - CW'(1);
            end
            default: begin
                bo_next = PQINF;
            end
        endcase
    end

    // Phase flag: the first edge after reset is an even-cycle edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd <= 1'b0;
        end else begin
            odd <= ~odd;
        end
    end

    // Registered outputs into node 1 and the occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo    <= PQINF;
            ao    <= PQNEGINF;
            count <= '0;
        end else begin
            bo    <= bo_next;
            ao    <= ao_next;
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_systolic_pq_head.sv
// Bench for systolic_pq_head. Two instances share all inputs: index 0 merges a
// simultaneous insert/extract into a replace, index 1 gives extract priority.
// A cycle-level model (phase bit, occupancy integer, expected entry pair) is
// advanced by tick() alongside the clock.
module tb_systolic_pq_head;

    localparam int KW  = 8;
    localparam int VW  = 4;
    localparam int W   = KW + VW;
    localparam int CAP = 4;
    localparam int CW  = $clog2(CAP + 1);
    localparam logic [W-1:0] INF = '1;
    localparam logic [W-1:0] NEG = '0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ins_valid = 1'b0;
    logic [W-1:0]  ins_data = '0;
    logic          ext_rdy = 1'b0;
    logic [W-1:0]  head_i = '0;

    logic          odd_o       [2];
    logic          even_o      [2];
    logic          ins_rdy_o   [2];
    logic          ext_valid_o [2];
    logic          full_o      [2];
    logic          empty_o     [2];
    logic [W-1:0]  ext_data_o  [2];
    logic [W-1:0]  bo_o        [2];
    logic [W-1:0]  ao_o        [2];
    logic [CW-1:0] count_o     [2];

    // Model state
    bit           m_odd;
    int           m_cnt [2];
    logic [W-1:0] m_bo  [2];
    logic [W-1:0] m_ao  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_pq_head #(.KW(KW), .VW(VW), .CAPACITY(CAP), .REPLACE_EN(1)) dut_rep (
        .clk(clk), .rst_n(rst_n), .odd(odd_o[0]), .even(even_o[0]),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_rdy(ins_rdy_o[0]),
        .ext_valid(ext_valid_o[0]), .ext_rdy(ext_rdy), .ext_data(ext_data_o[0]),
        .head_i(head_i), .bo(bo_o[0]), .ao(ao_o[0]), .count(count_o[0]),
        .full(full_o[0]), .empty(empty_o[0])
    );

    systolic_pq_head #(.KW(KW), .VW(VW), .CAPACITY(CAP), .REPLACE_EN(0)) dut_pri (
        .clk(clk), .rst_n(rst_n), .odd(odd_o[1]), .even(even_o[1]),
        .ins_valid(ins_valid), .ins_data(ins_data), .ins_rdy(ins_rdy_o[1]),
        .ext_valid(ext_valid_o[1]), .ext_rdy(ext_rdy), .ext_data(ext_data_o[1]),
        .head_i(head_i), .bo(bo_o[1]), .ao(ao_o[1]), .count(count_o[1]),
        .full(full_o[1]), .empty(empty_o[1])
    );

    // ---------------- model ----------------
    function automatic bit m_ext_valid(int k);
        return !m_odd && (m_cnt[k] > 0);
    endfunction

    // k == 0 is the replace instance
    function automatic bit m_ins_rdy(int k);
        return !m_odd && (m_cnt[k] < CAP) && (k == 0 || !(m_ext_valid(k) && ext_rdy));
    endfunction

    task automatic model_reset();
        m_odd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_bo[k]  = INF;
            m_ao[k]  = NEG;
        end
    endtask

    task automatic tick();
        logic [W-1:0] nb [2];
        logic [W-1:0] na [2];
        int           nc [2];
        for (int k = 0; k < 2; k++) begin
            bit ef;
            bit inf;
            ef    = m_ext_valid(k) && ext_rdy;
            inf   = m_ins_rdy(k) && ins_valid;
            nc[k] = m_cnt[k];
            if (inf && ef) begin
                nb[k] = ins_data;
                na[k] = INF;
            end else if (inf) begin
                nb[k] = ins_data;
                na[k] = NEG;
                nc[k] = m_cnt[k] + 1;
            end else if (ef) begin
                nb[k] = INF;
                na[k] = INF;
                nc[k] = m_cnt[k] - 1;
            end else begin
                nb[k] = INF;
                na[k] = NEG;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_bo[k]  = nb[k];
            m_ao[k]  = na[k];
            m_cnt[k] = nc[k];
        end
        m_odd = !m_odd;
    endtask

    task automatic apply_reset();
        ins_valid = 1'b0;
        ext_rdy   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
    endtask

    task automatic wait_even();
        ins_valid = 1'b0;
        ext_rdy   = 1'b0;
        for (int i = 0; i < 2 && m_odd; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (odd_o[k] !== 1'b0 || even_o[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_phase[%0d]: odd=%b even=%b, expected odd=0 even=1", k, odd_o[k], even_o[k]);
            end
            n_checks++;
            if (bo_o[k] !== 12'hFFF || ao_o[k] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_bo_ao[%0d]: bo=%h ao=%h, expected fff 000", k, bo_o[k], ao_o[k]);
            end
            n_checks++;
            if (count_o[k] !== 3'd0 || empty_o[k] !== 1'b1 || full_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_status[%0d]: count=%0d empty=%b full=%b, expected 0 1 0", k, count_o[k], empty_o[k], full_o[k]);
            end
        end
        release_reset();
    endtask

    task automatic test_fill();
        logic [KW-1:0] keys [4];
        int acc;
        keys = '{8'h30, 8'h10, 8'h40, 8'h20};
        acc  = 0;
        ins_valid = 1'b1;
        ext_rdy   = 1'b0;
        for (int cyc = 0; cyc < 20 && acc < 4; cyc++) begin
            bit take;
            ins_data = {keys[acc], 4'h0};
            #1;
            take = m_ins_rdy(0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (ins_rdy_o[k] !== m_ins_rdy(k) || odd_o[k] !== m_odd) begin
                    n_fail++;
                    $display("FAIL fill_rdy[%0d]: ins_rdy=%b odd=%b, expected %b %b", k, ins_rdy_o[k], odd_o[k], m_ins_rdy(k), m_odd);
                end
            end
            tick();
            if (take) begin
                acc++;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (bo_o[k] !== {keys[acc-1], 4'h0} || ao_o[k] !== NEG || count_o[k] !== CW'(acc)) begin
                        n_fail++;
                        $display("FAIL fill_accept[%0d]: bo=%h ao=%h count=%0d, expected %h 000 %0d",
                                 k, bo_o[k], ao_o[k], count_o[k], {keys[acc-1], 4'h0}, acc);
                    end
                end
            end
        end
        n_checks++;
        if (acc != 4) begin
            n_fail++;
            $display("FAIL fill_timeout: accepted %0d inserts, expected 4", acc);
        end
        ins_data = 12'h500;
        for (int cyc = 0; cyc < 2; cyc++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (ins_rdy_o[k] !== 1'b0 || full_o[k] !== 1'b1 || count_o[k] !== 3'd4) begin
                    n_fail++;
                    $display("FAIL full_hold[%0d]: ins_rdy=%b full=%b count=%0d, expected 0 1 4", k, ins_rdy_o[k], full_o[k], count_o[k]);
                end
            end
            tick();
        end
        ins_valid = 1'b0;
    endtask

    task automatic test_extract_full();
        wait_even();
        head_i  = 12'h100;
        ext_rdy = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (ext_valid_o[k] !== 1'b1 || ext_data_o[k] !== 12'h100) begin
                n_fail++;
                $display("FAIL ext_full_offer[%0d]: ext_valid=%b ext_data=%h, expected 1 100", k, ext_valid_o[k], ext_data_o[k]);
            end
        end
        tick();
        ext_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bo_o[k] !== 12'hFFF || ao_o[k] !== 12'hFFF || count_o[k] !== 3'd3 || full_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_full_result[%0d]: bo=%h ao=%h count=%0d full=%b, expected fff fff 3 0",
                         k, bo_o[k], ao_o[k], count_o[k], full_o[k]);
            end
        end
    endtask

    task automatic test_replace();
        // bring both instances down to two entries
        wait_even();
        ext_rdy = 1'b1;
        tick();
        wait_even();
        ins_valid = 1'b1;
        ins_data  = 12'h050;
        ext_rdy   = 1'b1;
        #1;
        n_checks++;
        if (ins_rdy_o[0] !== 1'b1 || ins_rdy_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_rdy: ins_rdy rep=%b pri=%b, expected 1 0", ins_rdy_o[0], ins_rdy_o[1]);
        end
        tick();
        ext_rdy = 1'b0;
        n_checks++;
        if (bo_o[0] !== 12'h050 || ao_o[0] !== 12'hFFF || count_o[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL replace_merge: bo=%h ao=%h count=%0d, expected 050 fff 2", bo_o[0], ao_o[0], count_o[0]);
        end
        n_checks++;
        if (bo_o[1] !== 12'hFFF || ao_o[1] !== 12'hFFF || count_o[1] !== 3'd1) begin
            n_fail++;
            $display("FAIL priority_extract: bo=%h ao=%h count=%0d, expected fff fff 1", bo_o[1], ao_o[1], count_o[1]);
        end
        n_checks++;
        if (ins_rdy_o[0] !== 1'b0 || ins_rdy_o[1] !== 1'b0 || ext_valid_o[0] !== 1'b0 || ext_valid_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_gate: ins_rdy=%b%b ext_valid=%b%b, expected all 0",
                     ins_rdy_o[0], ins_rdy_o[1], ext_valid_o[0], ext_valid_o[1]);
        end
        tick();
        n_checks++;
        if (ins_rdy_o[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL priority_retry_rdy: ins_rdy=%b, expected 1", ins_rdy_o[1]);
        end
        tick();
        ins_valid = 1'b0;
        n_checks++;
        if (bo_o[1] !== 12'h050 || ao_o[1] !== 12'h000 || count_o[1] !== 3'd2) begin
            n_fail++;
            $display("FAIL priority_retry: bo=%h ao=%h count=%0d, expected 050 000 2", bo_o[1], ao_o[1], count_o[1]);
        end
    endtask

    task automatic test_empty();
        apply_reset();
        release_reset();
        ext_rdy = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (ext_valid_o[k] !== 1'b0 || count_o[k] !== 3'd0 || bo_o[k] !== 12'hFFF || ao_o[k] !== 12'h000) begin
                    n_fail++;
                    $display("FAIL empty_extract[%0d] cyc %0d: ext_valid=%b count=%0d bo=%h ao=%h, expected 0 0 fff 000",
                             k, cyc, ext_valid_o[k], count_o[k], bo_o[k], ao_o[k]);
                end
            end
            tick();
        end
        ext_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        ext_rdy   = 1'b0;
        ins_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && m_cnt[0] < 3; cyc++) begin
            ins_data = W'($urandom);
            tick();
        end
        ins_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (odd_o[k] !== 1'b0 || even_o[k] !== 1'b1 || bo_o[k] !== INF || ao_o[k] !== NEG ||
                count_o[k] !== 3'd0 || empty_o[k] !== 1'b1 || full_o[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: odd=%b even=%b bo=%h ao=%h count=%0d empty=%b full=%b, expected 0 1 fff 000 0 1 0",
                         k, odd_o[k], even_o[k], bo_o[k], ao_o[k], count_o[k], empty_o[k], full_o[k]);
            end
        end
        model_reset();
        #1;
        rst_n     = 1'b1;
        ins_valid = 1'b1;
        ins_data  = 12'h0A5;
        tick();
        ins_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (count_o[k] !== 3'd1 || bo_o[k] !== 12'h0A5) begin
                n_fail++;
                $display("FAIL post_reset_insert[%0d]: count=%0d bo=%h, expected 1 0a5", k, count_o[k], bo_o[k]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        release_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit fill_bias;
            fill_bias = (cyc % 100) < 50;
            ins_valid = fill_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ext_rdy   = fill_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ins_data  = W'($urandom);
            head_i    = W'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                logic [5:0] exp_st;
                logic [5:0] got_st;
                exp_st = {m_odd, !m_odd, m_cnt[k] == CAP, m_cnt[k] == 0, m_ins_rdy(k), m_ext_valid(k)};
                got_st = {odd_o[k], even_o[k], full_o[k], empty_o[k], ins_rdy_o[k], ext_valid_o[k]};
                n_checks++;
                if (got_st !== exp_st) begin
                    n_fail++;
                    $display("FAIL rand_status[%0d] cyc %0d: {odd,even,full,empty,ins_rdy,ext_valid}=%b, expected %b",
                             k, cyc, got_st, exp_st);
                end
                n_checks++;
                if (count_o[k] !== CW'(m_cnt[k]) || bo_o[k] !== m_bo[k] || ao_o[k] !== m_ao[k]) begin
                    n_fail++;
                    $display("FAIL rand_regs[%0d] cyc %0d: count=%0d bo=%h ao=%h, expected %0d %h %h",
                             k, cyc, count_o[k], bo_o[k], ao_o[k], m_cnt[k], m_bo[k], m_ao[k]);
                end
                n_checks++;
                if (ext_data_o[k] !== head_i) begin
                    n_fail++;
                    $display("FAIL rand_ext_data[%0d] cyc %0d: ext_data=%h, expected %h", k, cyc, ext_data_o[k], head_i);
                end
            end
            tick();
        end
        ins_valid = 1'b0;
        ext_rdy   = 1'b0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_fill();
        test_extract_full();
        test_replace();
        test_empty();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
